// File: rtl/xdma_pkg.sv
// xdma_pkg: shared widths, FSM state encodings and config register indices for xdma
`ifndef XDMA_DEFS
`define XDMA_DEFS
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef ADDR_W
`define ADDR_W 8
`endif
`define XDMA_S_IDLE 3'd0
`define XDMA_S_RD 3'd1
`define XDMA_S_CAP 3'd2
`define XDMA_S_WR 3'd3
`define XDMA_S_FIN 3'd4
`define XDMA_REG_SRC 2'd0
`define XDMA_REG_DST 2'd1
`define XDMA_REG_LEN 2'd2
`define XDMA_REG_CTRL 2'd3
`endif
package xdma_pkg;
  localparam int DATA_W = `DATA_W;
  localparam int ADDR_W = `ADDR_W;
  typedef enum logic [2:0] {
    S_IDLE = `XDMA_S_IDLE,
    S_RD = `XDMA_S_RD,
    S_CAP = `XDMA_S_CAP,
    S_WR = `XDMA_S_WR,
    S_FIN = `XDMA_S_FIN
  } state_t;
  localparam logic [1:0] REG_SRC = `XDMA_REG_SRC;
  localparam logic [1:0] REG_DST = `XDMA_REG_DST;
  localparam logic [1:0] REG_LEN = `XDMA_REG_LEN;
  localparam logic [1:0] REG_CTRL = `XDMA_REG_CTRL;
endpackage

// File: rtl/xdma.sv
// xdma: single-channel word-copy DMA engine; CPU config slave (sel/we/addr/data_in/data_out), bus master (dma_*) yielding to cpu_sel, done flag
module xdma
  import xdma_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [`DATA_W-1:0] data_in,
  output logic [`DATA_W-1:0] data_out,
  input  logic               cpu_sel,
  output logic               dma_sel,
  output logic               dma_we,
  output logic [`ADDR_W-1:0] dma_addr,
  output logic [`DATA_W-1:0] dma_data_to_wr,
  input  logic [`DATA_W-1:0] dma_data_to_rd,
  output logic               done
);
  state_t r_state;
  logic [`ADDR_W-1:0] r_src, r_dst, r_src_cur, r_dst_cur;
  logic [`DATA_W-1:0] r_len, r_cnt, r_data;
  logic r_done;
  logic w_busy, w_wr, w_start, w_clr, w_rd_go, w_wr_go;
  assign w_busy = r_state != S_IDLE;
  assign w_wr = sel && we;
  assign w_start = w_wr && addr == REG_CTRL && data_in[0] && !w_busy;
  assign w_clr = w_wr && addr == REG_CTRL && data_in[1];
  // the CPU owns the bus whenever it asks; the DMA only drives idle cycles
  assign w_rd_go = r_state == S_RD && !cpu_sel;
  assign w_wr_go = r_state == S_WR && !cpu_sel;
  assign dma_sel = w_rd_go || w_wr_go;
  assign dma_we = w_wr_go;
  assign dma_addr = w_rd_go ? r_src_cur : w_wr_go ? r_dst_cur : '0;
  assign dma_data_to_wr = w_wr_go ? r_data : '0;
  assign done = r_done;
  assign data_out = addr == REG_SRC ? DATA_W'(r_src) :
                    addr == REG_DST ? DATA_W'(r_dst) :
                    addr == REG_LEN ? r_len :
                    {{(DATA_W-2){1'b0}}, r_done, w_busy};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_src_cur <= '0;
      r_dst_cur <= '0;
      r_cnt <= '0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_wr && !w_busy && addr == REG_SRC) r_src <= data_in[ADDR_W-1:0];
      if (w_wr && !w_busy && addr == REG_DST) r_dst <= data_in[ADDR_W-1:0];
      if (w_wr && !w_busy && addr == REG_LEN) r_len <= data_in;
      // a clear always wins, even against the FIN cycle that would set done
      if (w_clr || w_start) r_done <= 1'b0;
      else if (r_state == S_FIN) r_done <= 1'b1;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state <= r_len == '0 ? S_FIN : S_RD;
          r_src_cur <= r_src;
          r_dst_cur <= r_dst;
          r_cnt <= r_len;
        end
        S_RD: if (!cpu_sel) r_state <= S_CAP;
        S_CAP: begin
          r_data <= dma_data_to_rd;
          r_state <= S_WR;
        end
        S_WR: if (!cpu_sel) begin
          r_src_cur <= r_src_cur + 1'b1;
          r_dst_cur <= r_dst_cur + 1'b1;
          r_cnt <= r_cnt - 1'b1;
          r_state <= r_cnt != DATA_W'(1) ? S_RD : S_FIN;
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/xdma.md
XDMA -- requirements
Module: xdma

Interface
REQ-001 SHALL use macro `DATA_W, default from xdefs.vh, as the data word width.
REQ-002 SHALL use macro `ADDR_W, default from xdefs.vh, as the data bus address width.
REQ-003 SHALL have these ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have these CPU configuration slave ports:
- sel  in  1  config register select.
- we  in  1  config write strobe.
- addr  in  2  config register index.
- data_in  in  `DATA_W  config write data.
- data_out  out  `DATA_W  config read data, combinational.
REQ-005 SHALL have these bus master and status ports:
- cpu_sel  in  1  CPU data bus request this cycle; CPU has priority.
- dma_sel  out  1  DMA bus select.
- dma_we  out  1  DMA write strobe.
- dma_addr  out  `ADDR_W  DMA bus address.
- dma_data_to_wr  out  `DATA_W  DMA write data.
- dma_data_to_rd  in  `DATA_W  bus read data.
- done  out  1  transfer-complete flag.

Function
REQ-006 SHALL decode the config registers as follows:
- addr 0: SRC, R/W.
- addr 1: DST, R/W.
- addr 2: LEN, R/W, word count.
- addr 3: CTRL/STATUS. A write with bit0=1 means START. A write with bit1=1 clears done. A read returns {busy in bit0, done in bit1}, zero elsewhere.
REQ-007 SHALL ignore writes to SRC/DST/LEN and START while busy; a done-clear write SHALL always take effect.
REQ-008 SHALL implement the FSM IDLE, RD, CAP, WR, FIN; busy=1 in any state other than IDLE.
REQ-009 SHALL handle START in IDLE as follows:
- LEN==0: go to FIN.
- Otherwise: load working copies src_cur/dst_cur/cnt from SRC/DST/LEN and go to RD.
REQ-010 SHALL, in RD, assert dma_sel=1, dma_we=0, dma_addr=src_cur only when cpu_sel=0, then go to CAP. If cpu_sel=1, it SHALL hold RD with dma_sel=0.
REQ-011 SHALL, in CAP, latch dma_data_to_rd into an internal data register and go to WR; bus read latency is one cycle.
REQ-012 SHALL, in WR, assert dma_sel=1, dma_we=1, dma_addr=dst_cur, dma_data_to_wr=data register only when cpu_sel=0. It SHALL then increment src_cur and dst_cur, decrement cnt, and go to RD if cnt!=1, else to FIN. If cpu_sel=1, it SHALL hold WR.
REQ-013 SHALL, in FIN, set done=1 for one state cycle and return to IDLE; done SHALL stay set until cleared or a new START is accepted.
REQ-014 SHALL make dma_sel combinational from state and cpu_sel so that dma_sel and cpu_sel are never both 1.
REQ-015 SHALL wrap address increments modulo 2^`ADDR_W; wrap SHALL not abort the transfer.
REQ-016 SHALL, when START and a done-clear arrive in the same write, clear done and start.
REQ-017 SHALL drive dma_addr and dma_data_to_wr to 0 and dma_we to 0 whenever dma_sel=0.
REQ-018 SHALL take a minimum of 3 cycles per word with no CPU contention (RD, CAP, WR), plus 1 FIN cycle.

Reset
REQ-019 SHALL, on rst=1 at a clk edge, enter IDLE and clear SRC, DST, LEN, cnt, the data register and done; all outputs SHALL read 0 the cycle after.
REQ-020 SHALL, on reset mid-transfer, abort immediately, issue no further bus cycle and not set done.

Structure
REQ-021 SHALL place FSM state encodings and config register indices in xdefs.vh as `define constants.
REQ-022 SHALL be a single module with no sub-modules; the top level SHALL OR dma_sel into the address decoder select and mux addresses.

Verification
REQ-023 SHALL verify a basic copy: SRC=0x10, DST=0x40, LEN=4, START, cpu_sel=0 -> mem[0x40..0x43]=mem[0x10..0x13], done=1 after 13 cycles.
REQ-024 SHALL verify contention: same transfer with cpu_sel=1 on alternate cycles -> correct copy, dma_sel never coincides with cpu_sel.
REQ-025 SHALL verify a zero-length transfer: LEN=0, START -> no dma_sel pulse, done=1 within 2 cycles.
REQ-026 SHALL verify address wrap: SRC=2^`ADDR_W-2, LEN=4 -> reads at max-1, max, 0, 1.
REQ-027 SHALL verify busy protection: a SRC write and START during busy -> ignored, and STATUS reads busy=1.
REQ-028 SHALL verify reset mid-operation: rst during the 2nd word -> IDLE, done=0, dma_sel=0, and no 3rd word written.
